// File: rtl/multi_chan_counter_if.sv
// Control and status bundle for multi_chan_counter; master drives controls, slave returns counts.
// Per-channel fields are packed with channel i at [i*WIDTH +: WIDTH].
interface multi_chan_counter_if #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0]       en;
    logic [CHANNELS-1:0]       dir;
    logic [CHANNELS-1:0]       force_en;
    logic [CHANNELS*WIDTH-1:0] force_val;
    logic [CHANNELS*WIDTH-1:0] count;
    logic [CHANNELS-1:0]       tc;

    modport master (
        output en, dir, force_en, force_val,
        input  count, tc
    );

    modport slave (
        input  en, dir, force_en, force_val,
        output count, tc
    );
endinterface

// File: rtl/multi_chan_counter.sv
// N independent up/down counters with clear, override and wrap/saturate boundary flag.
// Latency: one registered cycle, no combinational path; no backpressure, inputs consumed every edge.
module multi_chan_counter #(
    parameter int WIDTH    = 4,
    parameter int CHANNELS = 2,
    parameter int SATURATE = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    multi_chan_counter_if.slave   bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX = '1;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic             tc_q;
        logic [WIDTH-1:0] stepped;
        logic             at_bound;

        assign at_bound = bus.dir[g] ? (cnt_q == MAX) : (cnt_q == '0);
        assign stepped  = bus.dir[g] ? (cnt_q + ONE) : (cnt_q - ONE);

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
                tc_q  <= 1'b0;
            end else if (bus.force_en[g]) begin
                cnt_q <= bus.force_val[g*WIDTH +: WIDTH];
                tc_q  <= 1'b0;
            end else if (!bus.en[g]) begin
                cnt_q <= '0;
                tc_q  <= 1'b0;
            end else if (at_bound && (SATURATE != 0)) begin
                // Blocked step: value holds, flag repeats every edge it stays blocked.
                tc_q  <= 1'b1;
            end else begin
                cnt_q <= stepped;
                tc_q  <= at_bound;
            end
        end

        assign bus.count[g*WIDTH +: WIDTH] = cnt_q;
        assign bus.tc[g]                   = tc_q;
    end
endmodule

// File: tb/tb_multi_chan_counter.sv
// Directed bench: wrap and saturate instances at 4x2, plus a wrap instance at 8x4.
module tb_multi_chan_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vecs = 0;
    int   errs = 0;

    always #5 clk = ~clk;

    multi_chan_counter_if #(.WIDTH(4), .CHANNELS(2)) bw ();
    multi_chan_counter_if #(.WIDTH(4), .CHANNELS(2)) bs ();
    multi_chan_counter_if #(.WIDTH(8), .CHANNELS(4)) b8 ();

    multi_chan_counter #(.WIDTH(4), .CHANNELS(2), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .bus(bw.slave)
    );
    multi_chan_counter #(.WIDTH(4), .CHANNELS(2), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .bus(bs.slave)
    );
    multi_chan_counter #(.WIDTH(8), .CHANNELS(4), .SATURATE(0)) u_w8 (
        .clk(clk), .rst(rst), .bus(b8.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Check both count and tc of the 4x2 wrap instance.
    task automatic chk_w(input string tag, input logic [7:0] cnt, input logic [1:0] tcv);
        chk({tag, ".count"}, 32'(bw.count), 32'(cnt));
        chk({tag, ".tc"},    32'(bw.tc),    32'(tcv));
    endtask

    task automatic chk_s(input string tag, input logic [7:0] cnt, input logic [1:0] tcv);
        chk({tag, ".count"}, 32'(bs.count), 32'(cnt));
        chk({tag, ".tc"},    32'(bs.tc),    32'(tcv));
    endtask

    initial begin
        bw.en = '0; bw.dir = '0; bw.force_en = '0; bw.force_val = '0;
        bs.en = '0; bs.dir = '0; bs.force_en = '0; bs.force_val = '0;
        b8.en = '0; b8.dir = '0; b8.force_en = '0; b8.force_val = '0;

        // Reset held two cycles
        rst = 1'b1;
        tick(); tick();
        chk_w("rst_w", 8'h00, 2'b00);
        chk_s("rst_s", 8'h00, 2'b00);
        chk("rst_w8.count", b8.count, 32'h0);
        chk("rst_w8.tc", 32'(b8.tc), 32'h0);

        // Count up on both channels, then clear ch0 for one cycle
        rst = 1'b0; bw.en = 2'b11; bw.dir = 2'b11;
        tick(); chk_w("up1", 8'h11, 2'b00);
        tick(); chk_w("up2", 8'h22, 2'b00);
        tick(); chk_w("up3", 8'h33, 2'b00);
        tick(); chk_w("up4", 8'h44, 2'b00);
        tick(); chk_w("up5", 8'h55, 2'b00);
        bw.en = 2'b10;
        tick(); chk_w("clr0", 8'h60, 2'b00);
        bw.en = 2'b11;
        tick(); chk_w("after_clr", 8'h71, 2'b00);

        // Wrap: ch0 up from 13, ch1 down from 1
        bw.force_en = 2'b11; bw.force_val = {4'd1, 4'd13};
        tick(); chk_w("wrap_load", 8'h1D, 2'b00);
        bw.force_en = 2'b00; bw.dir = 2'b01;
        tick(); chk_w("wrap_a", 8'h0E, 2'b00);
        tick(); chk_w("wrap_b", 8'hFF, 2'b10);
        tick(); chk_w("wrap_c", 8'hE0, 2'b01);
        tick(); chk_w("wrap_d", 8'hD1, 2'b00);

        // Override ch1: bring it to 3, force 9,9,11,11, release
        bw.dir = 2'b11; bw.force_en = 2'b10; bw.force_val = {4'd3, 4'd0};
        tick(); chk_w("ovr_pre", 8'h32, 2'b00);
        bw.force_val = {4'd9, 4'd0};
        tick(); chk_w("ovr1", 8'h93, 2'b00);
        tick(); chk_w("ovr2", 8'h94, 2'b00);
        bw.force_val = {4'd11, 4'd0};
        tick(); chk_w("ovr3", 8'hB5, 2'b00);
        tick(); chk_w("ovr4", 8'hB6, 2'b00);
        bw.force_en = 2'b00;
        tick(); chk_w("ovr_rel1", 8'hC7, 2'b00);
        tick(); chk_w("ovr_rel2", 8'hD8, 2'b00);

        // Priority: force beats en=0, reset beats force, force reloads after reset
        bw.force_en = 2'b01; bw.en = 2'b10; bw.force_val = {4'd0, 4'd7};
        tick(); chk_w("frc_vs_en", 8'hE7, 2'b00);
        rst = 1'b1;
        tick(); chk_w("rst_in_frc", 8'h00, 2'b00);
        rst = 1'b0;
        tick(); chk_w("frc_after_rst", 8'h17, 2'b00);
        bw.force_en = 2'b00; bw.en = 2'b11;
        tick(); chk_w("frc_release", 8'h28, 2'b00);

        // Force at the up boundary never flags; release then wraps with tc
        bw.force_en = 2'b01; bw.force_val = {4'd0, 4'd15};
        tick(); chk_w("frc_max1", 8'h3F, 2'b00);
        tick(); chk_w("frc_max2", 8'h4F, 2'b00);
        bw.force_en = 2'b00;
        tick(); chk_w("frc_max_rel", 8'h50, 2'b01);

        // Saturate: ch0 up from 13, ch1 down from 1
        bs.en = 2'b11; bs.dir = 2'b01; bs.force_en = 2'b11; bs.force_val = {4'd1, 4'd13};
        tick(); chk_s("sat_load", 8'h1D, 2'b00);
        bs.force_en = 2'b00;
        tick(); chk_s("sat_a", 8'h0E, 2'b00);
        tick(); chk_s("sat_b", 8'h0F, 2'b10);
        tick(); chk_s("sat_hold1", 8'h0F, 2'b11);
        tick(); chk_s("sat_hold2", 8'h0F, 2'b11);
        tick(); chk_s("sat_hold3", 8'h0F, 2'b11);
        bs.dir = 2'b00;
        tick(); chk_s("sat_down", 8'h0E, 2'b10);
        bs.dir = 2'b10;
        tick(); chk_s("sat_free", 8'h1D, 2'b00);

        // 8-bit, 4-channel wrap at both boundaries, no inter-channel carry
        b8.en = 4'b1111; b8.dir = 4'b0101; b8.force_en = 4'b1111;
        b8.force_val = {8'h00, 8'h80, 8'h01, 8'hFE};
        tick();
        chk("w8_load.count", b8.count, 32'h0080_01FE);
        chk("w8_load.tc", 32'(b8.tc), 32'h0);
        b8.force_en = 4'b0000;
        tick();
        chk("w8_a.count", b8.count, 32'hFF81_00FF);
        chk("w8_a.tc", 32'(b8.tc), 32'h8);
        tick();
        chk("w8_b.count", b8.count, 32'hFE82_FF00);
        chk("w8_b.tc", 32'(b8.tc), 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
